cpu_core: RTL and testbench



---
 rtl/cpu_core.sv | 110 +++++++++++
 tb/tb_cpu_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 8-bit register CPU with program counter, 1024x16 program ROM,
// 16x8 register file (R0 hard-wired to zero), 8-bit ALU, zero flag and absolute branches.
// Each rising clk edge commits one instruction.
module cpu_core #(
  parameter string       PROG_FILE = "progfile.dat",
  parameter int unsigned ROM_DEPTH = 1024
) (
  input  logic clk,
  input  logic reset
);

  localparam int unsigned PC_W    = $clog2(ROM_DEPTH);
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_N   = 16;
  localparam int unsigned REG_AW  = 4;

  // Program image, read combinationally at pc
  logic [INSTR_W-1:0] rom [0:ROM_DEPTH-1];

  // Architectural state (names kept fixed for probing)
  logic [PC_W-1:0]   pc;
  logic              z;
  logic [DATA_W-1:0] regs [0:REG_N-1];

  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    br_target;
  logic               z_d;

  logic [2:0]         alu_op;
  logic [REG_AW-1:0]  ra;
  logic [REG_AW-1:0]  rb;
  logic [REG_AW-1:0]  rd;
  logic [DATA_W-1:0]  a_val;
  logic [DATA_W-1:0]  b_val;
  logic [DATA_W-1:0]  alu_res;

  logic               rf_we;
  logic [REG_AW-1:0]  rf_wa;
  logic [DATA_W-1:0]  rf_wd;

  assign instr     = rom[pc];
  assign alu_op    = instr[14:12];
  assign ra        = instr[11:8];
  assign rb        = instr[7:4];
  assign rd        = instr[3:0];
  assign pc_inc    = pc + PC_W'(1);
  assign br_target = PC_W'(instr[9:0]);

  // Asynchronous register reads; R0 always reads as zero
  assign a_val = (ra == REG_AW'(0)) ? DATA_W'(0) : regs[ra];
  assign b_val = (rb == REG_AW'(0)) ? DATA_W'(0) : regs[rb];

  // 8-bit ALU, results wrap modulo 256
  always_comb begin
    alu_res = a_val;
    case (alu_op)
      3'b000:  alu_res = a_val;
      3'b001:  alu_res = ~a_val;
      3'b010:  alu_res = a_val + b_val;
      3'b011:  alu_res = a_val - b_val;
      3'b100:  alu_res = a_val & b_val;
      3'b101:  alu_res = a_val | b_val;
      3'b110:  alu_res = DATA_W'(0) - a_val;
      3'b111:  alu_res = DATA_W'(0) - b_val;
      default: alu_res = a_val;
    endcase
  end

  // Decode: next pc, next zero flag and register write request
  always_comb begin
    pc_d  = pc_inc;
    z_d   = z;
    rf_we = 1'b0;
    rf_wa = rd;
    rf_wd = alu_res;
    if (!instr[15]) begin
      // ALU op: z follows the result even when the write to R0 is dropped
      rf_we = (rd != REG_AW'(0));
      z_d   = (alu_res == DATA_W'(0));
    end else begin
      case (instr[14:12])
        3'b000: begin
          rf_we = (rd != REG_AW'(0));
          rf_wd = instr[11:4];
        end
        3'b001:  pc_d = br_target;
        3'b010:  if (z)  pc_d = br_target;
        3'b011:  if (!z) pc_d = br_target;
        default: ;
      endcase
    end
  end

  // State commit; reset clears everything immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      z  <= 1'b0;
      for (int i = 0; i < int'(REG_N); i++) regs[i] <= '0;
    end else begin
      pc <= pc_d;
      z  <= z_d;
      if (rf_we) regs[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs written into the ROM, expectations queued per
// cycle and checked by an independent negedge monitor against probed pc, z and regs.
module tb_cpu_core;

  localparam int K_PC  = 0;
  localparam int K_Z   = 1;
  localparam int K_REG = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #20 clk = ~clk;

  cpu_core #(.PROG_FILE(""), .ROM_DEPTH(1024)) dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct {
    string      name;
    int         at;
    int         kind;
    logic [3:0] idx;
    int         val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          base   = 0;
  bit          done   = 1'b0;
  logic [15:0] img[$];

  // Free-running edge counter used to time expectations
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due at this cycle
  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_PC:    act = int'(dut.pc);
        K_Z:     act = int'(dut.z);
        default: act = int'(dut.regs[e.idx]);
      endcase
      checks++;
      if (e.at != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s: actual %0d required %0d (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc, e.at);
      end
    end
    if (done) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: never reached, required %0d", e.name, e.val);
      end
    end
  end

  task automatic push(input string name, input int k, input int kind, input int idx, input int val);
    exp_t e;
    e.name = name;
    e.at   = base + k;
    e.kind = kind;
    e.idx  = 4'(idx);
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic exp_pc(input string name, input int k, input int v);
    push(name, k, K_PC, 0, v);
  endtask

  task automatic exp_z(input string name, input int k, input int v);
    push(name, k, K_Z, 0, v);
  endtask

  task automatic exp_r(input string name, input int k, input int r, input int v);
    push(name, k, K_REG, r, v);
  endtask

  // Fill ROM with NOPs, then the program in img from address 0
  task automatic load_prog();
    for (int i = 0; i < 1024; i++) dut.rom[i] = 16'hC000;
    for (int i = 0; i < img.size(); i++) dut.rom[i] = img[i];
  endtask

  task automatic assert_rst();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic release_rst();
    #10 reset = 1'b1;
    base = cyc;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, LI and ADD
    assert_rst();
    img = '{16'h8051, 16'h8032, 16'h2123, 16'h9003};
    load_prog();
    release_rst();
    exp_pc("rst_pc", 0, 0);
    exp_z("rst_z", 0, 0);
    exp_r("rst_r1", 0, 1, 0);
    exp_r("rst_r3", 0, 3, 0);
    exp_pc("first_edge_pc", 1, 1);
    exp_r("li_r1", 1, 1, 5);
    exp_r("li_r2", 2, 2, 3);
    exp_r("add_r3", 3, 3, 8);
    exp_z("add_z", 3, 0);
    exp_pc("add_pc", 3, 3);
    exp_pc("jself_pc", 5, 3);
    run(7);

    // SUB to zero then JZ taken
    assert_rst();
    img = '{16'h8071, 16'h3114, 16'hA00A};
    load_prog();
    dut.rom[10] = 16'h900A;
    release_rst();
    exp_pc("rst2_pc", 0, 0);
    exp_r("rst2_r3_cleared", 0, 3, 0);
    exp_r("sub_r4", 2, 4, 0);
    exp_z("sub_z", 2, 1);
    exp_pc("jz_taken_pc", 3, 10);
    exp_pc("jz_hold_pc", 5, 10);
    run(7);

    // Same point with JNZ falls through
    assert_rst();
    img = '{16'h8071, 16'h3114, 16'hB00A, 16'h9003};
    load_prog();
    dut.rom[10] = 16'h900A;
    release_rst();
    exp_z("rst3_z_cleared", 0, 0);
    exp_z("sub3_z", 2, 1);
    exp_pc("jnz_fall_pc", 3, 3);
    exp_pc("jnz_hold_pc", 4, 3);
    run(6);

    // ALU coverage with A=0x0F, B=0xF0
    assert_rst();
    img = '{16'h80F1, 16'h8F02, 16'h1103, 16'h4124, 16'h8019, 16'h5125,
            16'h6106, 16'h7027, 16'h2128, 16'h289A, 16'h010B, 16'h900B};
    load_prog();
    release_rst();
    exp_r("not_a", 3, 3, 8'hF0);
    exp_z("not_z", 3, 0);
    exp_r("and_ab", 4, 4, 8'h00);
    exp_z("and_z", 4, 1);
    exp_r("li_r9", 5, 9, 1);
    exp_z("li_keeps_z", 5, 1);
    exp_r("or_ab", 6, 5, 8'hFF);
    exp_z("or_z", 6, 0);
    exp_r("neg_a", 7, 6, 8'hF1);
    exp_r("neg_b", 8, 7, 8'h10);
    exp_r("add_ab", 9, 8, 8'hFF);
    exp_r("add_wrap", 10, 10, 8'h00);
    exp_z("add_wrap_z", 10, 1);
    exp_r("mov_a", 11, 11, 8'h0F);
    exp_z("mov_z", 11, 0);
    exp_pc("alu_end_pc", 12, 11);
    run(14);

    // R0 hard-wired, ALU to R0 still sets z, J 1023 then wrap
    assert_rst();
    img = '{16'h8550, 16'h8011, 16'h2005, 16'h2110, 16'h93FF};
    load_prog();
    dut.rom[1023] = 16'hC000;
    release_rst();
    exp_r("li_r0_dropped", 1, 0, 0);
    exp_r("li_r1_one", 2, 1, 1);
    exp_r("add_r0_r5", 3, 5, 0);
    exp_z("add_r0_z", 3, 1);
    exp_z("rd0_z_update", 4, 0);
    exp_r("rd0_write_dropped", 4, 0, 0);
    exp_pc("j_1023", 5, 1023);
    exp_pc("pc_wrap", 6, 0);
    exp_pc("after_wrap", 7, 1);
    run(9);

    // Count-down loop with asynchronous reset mid-run
    assert_rst();
    img = '{16'h8091, 16'h8012, 16'h3121, 16'hB002, 16'h9004};
    load_prog();
    release_rst();
    exp_pc("loop_pc_e4", 4, 2);
    exp_r("loop_r1_e4", 4, 1, 8);
    exp_pc("async_pc", 5, 0);
    exp_z("async_z", 5, 0);
    exp_r("async_r1", 5, 1, 0);
    exp_r("async_r2", 5, 2, 0);
    run(5);
    #15 reset = 1'b0;
    #15 reset = 1'b1;
    base = cyc;
    exp_r("loop_r1_it1", 3, 1, 8);
    exp_z("loop_z_it1", 3, 0);
    exp_pc("loop_back", 4, 2);
    exp_r("loop_r1_done", 19, 1, 0);
    exp_z("loop_z_done", 19, 1);
    exp_pc("loop_exit_pc", 20, 4);
    exp_pc("loop_hold_pc", 22, 4);
    run(24);

    done = 1'b1;
    run(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
